dma_xfer_splitter: RTL and testbench
====================================

Name: dma_xfer_splitter

Overview:
- Synthesizable command front-end for one direct-DMA engine channel (S2C or C2S).
- Accepts whole-transfer commands `{sys_addr, card_addr, bcount}` and splits each at MAX_BYTES system-address boundaries.
- Issues block-mode descriptors on the engine's desc_req/desc_ready interface, with first/last chain flags.
- Counts desc_done completions and returns one aggregated 160-bit status per command.

Parameters:
- MAX_BYTES_LOG2, 12, log2 of the maximum descriptor byte count and its alignment (MAX_BYTES = 1<<MAX_BYTES_LOG2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- cmd_sys_addr  in  64  system start address
- cmd_card_addr  in  64  card start address
- cmd_bcount  in  32  total byte count
- abort  in  1  pulse: abort the current command
- desc_req  out  1  descriptor request
- desc_ready  in  1  engine accept
- desc_ptr  out  32  always 0
- desc_data  out  256  block-mode descriptor
- desc_abort  out  1  engine abort request
- desc_abort_ack  in  1  engine abort acknowledge
- desc_done  in  1  descriptor complete (level, may last several cycles)
- desc_done_status  in  160  completion status; [63:32] = bytes done
- rsp_valid  out  1  one-cycle pulse: command finished
- rsp_status  out  160  `{last_status[159:64], done_bytes, last_status[31:0]}`
- rsp_error  out  1  valid with rsp_valid: bcount was 0
- rsp_aborted  out  1  valid with rsp_valid: command was aborted
- busy  out  1  command in progress

Behaviour:
- Reset values:
  - all outputs 0, except cmd_ready=1 (IDLE).
  - desc_data=0; all counters and accumulators 0.
  - Reset mid-operation drops desc_req/desc_abort asynchronously; no rsp is produced.
- Descriptor layout:
  - [0]=last, [9:1]=0, [10]=first, [11]=last, [31:12]=0
  - [63:32]=chunk bcount, [127:64]=sys_addr, [191:128]=card_addr, [255:192]=0
- Split arithmetic:
  - max = MAX_BYTES − (sys_addr mod MAX_BYTES)
  - chunk = min(remaining, max)
  - first=1 only on descriptor 0; last=1 when chunk==remaining.
  - After acceptance, sys_addr and card_addr += chunk, remaining −= chunk.
  - Address arithmetic is 64-bit and wraps silently.
- FSM states IDLE, ISSUE, RELEASE, DRAIN, ABORT, RESP:
  - IDLE: cmd_ready=1. On handshake:
    - bcount==0 → RESP with error=1, status 0.
    - else latch the command, compute the first chunk, → ISSUE.
  - ISSUE: desc_req=1 and desc_data stable. On desc_ready=1 → RELEASE (req deasserted next cycle); num_issued++.
  - RELEASE: desc_req=0. Wait for desc_ready=0, then:
    - if remaining != 0 → ISSUE with the next chunk (registered, so desc_data updates before req rises);
    - else → DRAIN.
  - DRAIN: wait until num_done == num_issued → RESP.
  - RESP: rsp_valid=1 for one cycle → IDLE. rsp_status is held until the next rsp_valid.
- Completion tracking:
  - Runs in every non-IDLE state, concurrently with issuing.
  - A completion is counted on the rising edge of desc_done (registered previous value): num_done++, done_bytes += desc_done_status[63:32] (32-bit wrap), last_status latched.
  - A done held high for N cycles counts once.
  - A done rise in the same cycle as a DRAIN check is included before the compare.
- Counters num_issued and num_done are 32-bit.
- Abort:
  - abort in ISSUE/RELEASE/DRAIN → ABORT; desc_req=0 immediately (registered).
  - In ABORT: desc_abort=1 until desc_abort_ack=1, then deasserted next cycle → RESP with aborted=1 and the partial status.
  - abort in IDLE or RESP is ignored.
  - abort has priority over a simultaneous desc_ready.
- busy=1 in all states except IDLE.

Decomposition:
- Shared package `dma_desc_pkg`:
  - descriptor field bit positions, DESC_W=256, STATUS_W=160;
  - a function `build_block_desc(first, last, sys, card, bcount)`;
  - the state enum.
- One sub-module, `dma_chunk_calc`: combinational chunk/last computation from {sys_addr, remaining}.

Test Plan:
- **Single descriptor:** sys 0x1000, card 0x0, bcount 0x100 → one desc with first=last=1, [63:32]=0x100; done status[63:32]=0x100 → rsp_status[63:32]=0x100, no error/abort.
- **Boundary split:** sys 0x0F00, card 0x8000, bcount 0x1200 → three descriptors:
  - 0x100 @0x0F00/0x8000 (first=1)
  - 0x1000 @0x1000/0x8100
  - 0x100 @0x2000/0x9100 (last=1)
  - Three dones → rsp bytes 0x1200.
- **Zero length:** bcount 0 → rsp_valid next cycle with rsp_error=1; desc_req never asserted.
- **Overlapping and long dones:** done for descriptor 0 arrives during ISSUE of descriptor 1 and is held 5 cycles → counted once; rsp only after the third done rise.
- **Abort mid-chain:** abort after the first acceptance → desc_req low; desc_abort held until ack (ack after 4 cycles); rsp_aborted=1 with rsp bytes equal to the completions seen so far.
- **Reset mid-ISSUE:** assert rst while desc_req=1 → desc_req=0 without a clock edge; cmd_ready=1 after release; a following command runs normally.

Source files
------------

// File: rtl/dma_desc_pkg.sv
// Shared definitions for the DMA transfer splitter: descriptor layout, widths,
// FSM state encoding and the block-mode descriptor builder.
package dma_desc_pkg;

  localparam int unsigned DESC_W   = 256;
  localparam int unsigned STATUS_W = 160;
  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned BCOUNT_W = 32;

  localparam int unsigned DESC_LAST0_BIT = 0;
  localparam int unsigned DESC_FIRST_BIT = 10;
  localparam int unsigned DESC_LAST_BIT  = 11;
  localparam int unsigned DESC_BCNT_LSB  = 32;
  localparam int unsigned DESC_SYS_LSB   = 64;
  localparam int unsigned DESC_CARD_LSB  = 128;

  localparam int unsigned STATUS_BYTES_LSB = 32;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StRelease,
    StDrain,
    StAbort,
    StResp
  } state_e;

  function automatic logic [DESC_W-1:0] build_block_desc(
    input logic                first,
    input logic                last,
    input logic [ADDR_W-1:0]   sys,
    input logic [ADDR_W-1:0]   card,
    input logic [BCOUNT_W-1:0] bcount
  );
    logic [DESC_W-1:0] d;
    d                               = '0;
    d[DESC_LAST0_BIT]               = last;
    d[DESC_FIRST_BIT]               = first;
    d[DESC_LAST_BIT]                = last;
    d[DESC_BCNT_LSB +: BCOUNT_W]    = bcount;
    d[DESC_SYS_LSB +: ADDR_W]       = sys;
    d[DESC_CARD_LSB +: ADDR_W]      = card;
    return d;
  endfunction

endpackage

// File: rtl/dma_chunk_calc.sv
// Combinational chunk sizing: largest piece of the remaining transfer that does
// not cross the next MAX_BYTES system-address boundary.
module dma_chunk_calc
  import dma_desc_pkg::*;
#(
  parameter int unsigned MAX_BYTES_LOG2 = 12
) (
  input  logic [ADDR_W-1:0]   sys_addr,
  input  logic [BCOUNT_W-1:0] remaining,
  output logic [BCOUNT_W-1:0] chunk,
  output logic                last
);

  logic [BCOUNT_W-1:0] offset;
  logic [BCOUNT_W-1:0] max_bytes;

  always_comb begin
    offset                      = '0;
    offset[MAX_BYTES_LOG2-1:0]  = sys_addr[MAX_BYTES_LOG2-1:0];
    max_bytes                   = (BCOUNT_W'(1) << MAX_BYTES_LOG2) - offset;
    chunk                       = (remaining < max_bytes) ? remaining : max_bytes;
    last                        = (chunk == remaining);
  end

endmodule

// File: rtl/dma_xfer_splitter.sv
// Command front-end for one direct-DMA channel: splits whole transfers into
// boundary-aligned block descriptors and aggregates their completions.
module dma_xfer_splitter
  import dma_desc_pkg::*;
#(
  parameter int unsigned MAX_BYTES_LOG2 = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [63:0]         cmd_sys_addr,
  input  logic [63:0]         cmd_card_addr,
  input  logic [31:0]         cmd_bcount,
  input  logic                abort,
  output logic                desc_req,
  input  logic                desc_ready,
  output logic [31:0]         desc_ptr,
  output logic [255:0]        desc_data,
  output logic                desc_abort,
  input  logic                desc_abort_ack,
  input  logic                desc_done,
  input  logic [159:0]        desc_done_status,
  output logic                rsp_valid,
  output logic [159:0]        rsp_status,
  output logic                rsp_error,
  output logic                rsp_aborted,
  output logic                busy
);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    sys_q, sys_d, card_q, card_d;
  logic [BCOUNT_W-1:0]  rem_q, rem_d, chunk_q, chunk_d;
  logic [DESC_W-1:0]    desc_q, desc_d;
  logic [31:0]          num_issued_q, num_issued_d;
  logic [31:0]          num_done_q, num_done_d;
  logic [31:0]          done_bytes_q, done_bytes_d;
  logic [STATUS_W-1:0]  last_status_q, last_status_d;
  logic [STATUS_W-1:0]  rsp_status_q, rsp_status_d;
  logic                 rsp_error_q, rsp_error_d;
  logic                 rsp_aborted_q, rsp_aborted_d;
  logic                 done_prev_q;
  logic                 done_rise;

  logic [ADDR_W-1:0]    calc_sys;
  logic [BCOUNT_W-1:0]  calc_rem, calc_chunk;
  logic                 calc_last;

  // In IDLE the first chunk is sized straight from the incoming command.
  always_comb begin
    calc_sys = (state_q == StIdle) ? cmd_sys_addr : sys_q;
    calc_rem = (state_q == StIdle) ? cmd_bcount : rem_q;
  end

  dma_chunk_calc #(
    .MAX_BYTES_LOG2(MAX_BYTES_LOG2)
  ) u_chunk_calc (
    .sys_addr (calc_sys),
    .remaining(calc_rem),
    .chunk    (calc_chunk),
    .last     (calc_last)
  );

  assign done_rise = desc_done & ~done_prev_q;

  always_comb begin
    state_d       = state_q;
    sys_d         = sys_q;
    card_d        = card_q;
    rem_d         = rem_q;
    chunk_d       = chunk_q;
    desc_d        = desc_q;
    num_issued_d  = num_issued_q;
    num_done_d    = num_done_q;
    done_bytes_d  = done_bytes_q;
    last_status_d = last_status_q;
    rsp_status_d  = rsp_status_q;
    rsp_error_d   = rsp_error_q;
    rsp_aborted_d = rsp_aborted_q;

    // Completions are tracked before the FSM so a DRAIN compare sees this cycle's rise.
    if (state_q != StIdle && done_rise) begin
      num_done_d    = num_done_q + 32'd1;
      done_bytes_d  = done_bytes_q + desc_done_status[STATUS_BYTES_LSB +: 32];
      last_status_d = desc_done_status;
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          num_issued_d  = '0;
          num_done_d    = '0;
          done_bytes_d  = '0;
          last_status_d = '0;
          if (cmd_bcount == '0) begin
            rsp_status_d  = '0;
            rsp_error_d   = 1'b1;
            rsp_aborted_d = 1'b0;
            state_d       = StResp;
          end else begin
            sys_d   = cmd_sys_addr;
            card_d  = cmd_card_addr;
            rem_d   = cmd_bcount;
            chunk_d = calc_chunk;
            desc_d  = build_block_desc(1'b1, calc_last, cmd_sys_addr, cmd_card_addr, calc_chunk);
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (abort) begin
          state_d = StAbort;
        end else if (desc_ready) begin
          num_issued_d = num_issued_q + 32'd1;
          sys_d        = sys_q + {32'b0, chunk_q};
          card_d       = card_q + {32'b0, chunk_q};
          rem_d        = rem_q - chunk_q;
          state_d      = StRelease;
        end
      end
      StRelease: begin
        if (abort) begin
          state_d = StAbort;
        end else if (!desc_ready) begin
          if (rem_q != '0) begin
            chunk_d = calc_chunk;
            desc_d  = build_block_desc(1'b0, calc_last, sys_q, card_q, calc_chunk);
            state_d = StIssue;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (abort) begin
          state_d = StAbort;
        end else if (num_done_d == num_issued_q) begin
          rsp_status_d  = {last_status_d[159:64], done_bytes_d, last_status_d[31:0]};
          rsp_error_d   = 1'b0;
          rsp_aborted_d = 1'b0;
          state_d       = StResp;
        end
      end
      StAbort: begin
        if (desc_abort_ack) begin
          rsp_status_d  = {last_status_d[159:64], done_bytes_d, last_status_d[31:0]};
          rsp_error_d   = 1'b0;
          rsp_aborted_d = 1'b1;
          state_d       = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      sys_q         <= '0;
      card_q        <= '0;
      rem_q         <= '0;
      chunk_q       <= '0;
      desc_q        <= '0;
      num_issued_q  <= '0;
      num_done_q    <= '0;
      done_bytes_q  <= '0;
      last_status_q <= '0;
      rsp_status_q  <= '0;
      rsp_error_q   <= 1'b0;
      rsp_aborted_q <= 1'b0;
      done_prev_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sys_q         <= sys_d;
      card_q        <= card_d;
      rem_q         <= rem_d;
      chunk_q       <= chunk_d;
      desc_q        <= desc_d;
      num_issued_q  <= num_issued_d;
      num_done_q    <= num_done_d;
      done_bytes_q  <= done_bytes_d;
      last_status_q <= last_status_d;
      rsp_status_q  <= rsp_status_d;
      rsp_error_q   <= rsp_error_d;
      rsp_aborted_q <= rsp_aborted_d;
      done_prev_q   <= desc_done;
    end
  end

  // Handshake outputs decode the registered state, so reset drops them at once.
  assign cmd_ready   = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign desc_req    = (state_q == StIssue);
  assign desc_abort  = (state_q == StAbort);
  assign rsp_valid   = (state_q == StResp);
  assign desc_ptr    = '0;
  assign desc_data   = desc_q;
  assign rsp_status  = rsp_status_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_aborted = rsp_aborted_q;

endmodule

// File: tb/tb_dma_xfer_splitter.sv
// Directed, table-driven bench for dma_xfer_splitter with hand-written
// sequences for overlapping completions, abort and mid-transfer reset.
module tb_dma_xfer_splitter;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [63:0]  cmd_sys_addr;
  logic [63:0]  cmd_card_addr;
  logic [31:0]  cmd_bcount;
  logic         abort;
  logic         desc_req;
  logic         desc_ready;
  logic [31:0]  desc_ptr;
  logic [255:0] desc_data;
  logic         desc_abort;
  logic         desc_abort_ack;
  logic         desc_done;
  logic [159:0] desc_done_status;
  logic         rsp_valid;
  logic [159:0] rsp_status;
  logic         rsp_error;
  logic         rsp_aborted;
  logic         busy;

  always #5 clk = ~clk;

  dma_xfer_splitter #(
    .MAX_BYTES_LOG2(12)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_sys_addr    (cmd_sys_addr),
    .cmd_card_addr   (cmd_card_addr),
    .cmd_bcount      (cmd_bcount),
    .abort           (abort),
    .desc_req        (desc_req),
    .desc_ready      (desc_ready),
    .desc_ptr        (desc_ptr),
    .desc_data       (desc_data),
    .desc_abort      (desc_abort),
    .desc_abort_ack  (desc_abort_ack),
    .desc_done       (desc_done),
    .desc_done_status(desc_done_status),
    .rsp_valid       (rsp_valid),
    .rsp_status      (rsp_status),
    .rsp_error       (rsp_error),
    .rsp_aborted     (rsp_aborted),
    .busy            (busy)
  );

  typedef struct {
    logic [63:0] sys;
    logic [63:0] card;
    logic [31:0] bcount;
    int          dstart;
    int          ndesc;
  } cmd_t;

  typedef struct {
    logic        first;
    logic        last;
    logic [31:0] bc;
    logic [63:0] sys;
    logic [63:0] card;
  } dexp_t;

  cmd_t  cmds[5];
  dexp_t dexp[9];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [159:0] mk_status(input int tag, input logic [31:0] bytes);
    return {32'hABCD0000 + 32'(tag), 64'h1122334455667788, bytes, 32'h5A000000 + 32'(tag)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [63:0] sys, input logic [63:0] card, input logic [31:0] bc);
    for (int i = 0; i < 50 && !cmd_ready; i++) tick();
    chk("cmd_ready before command", cmd_ready, 1);
    cmd_valid     = 1'b1;
    cmd_sys_addr  = sys;
    cmd_card_addr = card;
    cmd_bcount    = bc;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic expect_desc(input int di);
    dexp_t d;
    d = dexp[di];
    for (int i = 0; i < 50 && !desc_req; i++) tick();
    chk($sformatf("desc_req for desc %0d", di), desc_req, 1);
    chk($sformatf("desc_data for desc %0d", di), desc_data,
        {64'h0, d.card, d.sys, d.bc, 20'h0, d.last, d.first, 9'h0, d.last});
    chk("busy while issuing", busy, 1);
    desc_ready = 1'b1;
    tick();
    desc_ready = 1'b0;
    chk($sformatf("desc_req drop after desc %0d", di), desc_req, 0);
  endtask

  task automatic pulse_done(input logic [159:0] st);
    desc_done_status = st;
    desc_done        = 1'b1;
    tick();
    desc_done        = 1'b0;
  endtask

  task automatic expect_rsp(input logic [159:0] st, input logic err, input logic abt);
    for (int i = 0; i < 50 && !rsp_valid; i++) tick();
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_status", rsp_status, st);
    chk("rsp_error", rsp_error, err);
    chk("rsp_aborted", rsp_aborted, abt);
    tick();
    chk("rsp_valid one cycle", rsp_valid, 0);
    chk("rsp_status held", rsp_status, st);
    chk("cmd_ready after rsp", cmd_ready, 1);
  endtask

  task automatic run_cmd(input int ci);
    logic [31:0] total;
    cmd_t c;
    c     = cmds[ci];
    total = '0;
    issue_cmd(c.sys, c.card, c.bcount);
    for (int k = 0; k < c.ndesc; k++) begin
      expect_desc(c.dstart + k);
      pulse_done(mk_status(ci, dexp[c.dstart + k].bc));
      total = total + dexp[c.dstart + k].bc;
    end
    expect_rsp(mk_status(ci, total), 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    logic held;

    cmds[0] = '{64'h1000, 64'h0, 32'h100, 0, 1};
    cmds[1] = '{64'h0F00, 64'h8000, 32'h1200, 1, 3};
    cmds[2] = '{64'h1FFF, 64'h10, 32'h2, 4, 2};
    cmds[3] = '{64'hFFFF_FFFF_FFFF_FF00, 64'hFFFF_FFFF_FFFF_FFF0, 32'h200, 6, 2};
    cmds[4] = '{64'h3000, 64'h40, 32'h1000, 8, 1};

    dexp[0] = '{1'b1, 1'b1, 32'h100, 64'h1000, 64'h0};
    dexp[1] = '{1'b1, 1'b0, 32'h100, 64'h0F00, 64'h8000};
    dexp[2] = '{1'b0, 1'b0, 32'h1000, 64'h1000, 64'h8100};
    dexp[3] = '{1'b0, 1'b1, 32'h100, 64'h2000, 64'h9100};
    dexp[4] = '{1'b1, 1'b0, 32'h1, 64'h1FFF, 64'h10};
    dexp[5] = '{1'b0, 1'b1, 32'h1, 64'h2000, 64'h11};
    dexp[6] = '{1'b1, 1'b0, 32'h100, 64'hFFFF_FFFF_FFFF_FF00, 64'hFFFF_FFFF_FFFF_FFF0};
    dexp[7] = '{1'b0, 1'b1, 32'h100, 64'h0, 64'hF0};
    dexp[8] = '{1'b1, 1'b1, 32'h1000, 64'h3000, 64'h40};

    rst              = 1'b1;
    cmd_valid        = 1'b0;
    cmd_sys_addr     = '0;
    cmd_card_addr    = '0;
    cmd_bcount       = '0;
    abort            = 1'b0;
    desc_ready       = 1'b0;
    desc_abort_ack   = 1'b0;
    desc_done        = 1'b0;
    desc_done_status = '0;
    repeat (3) tick();

    // Reset state
    chk("reset cmd_ready", cmd_ready, 1);
    chk("reset desc_req", desc_req, 0);
    chk("reset desc_abort", desc_abort, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset desc_data", desc_data, 0);
    chk("reset desc_ptr", desc_ptr, 0);
    chk("reset rsp_status", rsp_status, 0);
    rst = 1'b0;
    tick();

    // Abort while idle is ignored
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle abort ignored busy", busy, 0);
    chk("idle abort ignored cmd_ready", cmd_ready, 1);

    for (int ci = 0; ci < 5; ci++) run_cmd(ci);

    // Zero length: response on the very next cycle, no descriptor
    issue_cmd(64'h5000, 64'h6000, 32'h0);
    chk("zero rsp_valid", rsp_valid, 1);
    chk("zero rsp_error", rsp_error, 1);
    chk("zero rsp_aborted", rsp_aborted, 0);
    chk("zero rsp_status", rsp_status, 0);
    chk("zero desc_req", desc_req, 0);
    tick();
    chk("zero rsp one cycle", rsp_valid, 0);
    chk("zero desc_req after", desc_req, 0);
    chk("zero cmd_ready after", cmd_ready, 1);

    // Overlapping, long done for descriptor 0
    issue_cmd(cmds[1].sys, cmds[1].card, cmds[1].bcount);
    expect_desc(1);
    desc_done_status = mk_status(30, 32'h100);
    desc_done        = 1'b1;
    expect_desc(2);
    repeat (3) tick();
    desc_done = 1'b0;
    expect_desc(3);
    pulse_done(mk_status(31, 32'h1000));
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid) seen = 1'b1;
      tick();
    end
    if (rsp_valid) seen = 1'b1;
    chk("no rsp before third done", seen, 0);
    pulse_done(mk_status(32, 32'h100));
    expect_rsp(mk_status(32, 32'h1200), 1'b0, 1'b0);

    // Abort mid-chain, simultaneous with desc_ready
    issue_cmd(cmds[1].sys, cmds[1].card, cmds[1].bcount);
    expect_desc(1);
    pulse_done(mk_status(20, 32'h100));
    for (int i = 0; i < 50 && !desc_req; i++) tick();
    chk("abort: desc_req before abort", desc_req, 1);
    abort      = 1'b1;
    desc_ready = 1'b1;
    tick();
    abort      = 1'b0;
    desc_ready = 1'b0;
    chk("abort: desc_req low", desc_req, 0);
    chk("abort: desc_abort high", desc_abort, 1);
    held = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!desc_abort || desc_req) held = 1'b0;
    end
    chk("abort: desc_abort held until ack", held, 1);
    desc_abort_ack = 1'b1;
    tick();
    desc_abort_ack = 1'b0;
    chk("abort: desc_abort drop", desc_abort, 0);
    expect_rsp(mk_status(20, 32'h100), 1'b0, 1'b1);

    // Reset in the middle of ISSUE
    issue_cmd(cmds[1].sys, cmds[1].card, cmds[1].bcount);
    chk("reset test: desc_req up", desc_req, 1);
    #3 rst = 1'b1;
    #1;
    chk("async reset drops desc_req", desc_req, 0);
    chk("async reset cmd_ready", cmd_ready, 1);
    chk("async reset busy", busy, 0);
    tick();
    chk("no rsp on reset", rsp_valid, 0);
    rst = 1'b0;
    tick();
    run_cmd(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
